// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: IDLE/WAIT/LOAD handshake with redirect support.
// Optional fetch timeout and ERR state enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] Inst,
    output logic        IRWrite,
    output logic [31:0] PC,
    output logic        busy,
    output logic        fetch_err
);

`ifdef IFETCH_TIMEOUT_EN
    typedef enum logic [1:0] {
        S_IDLE, S_WAIT, S_LOAD, S_ERR
    } state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_WAIT, S_LOAD
    } state_t;
`endif

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_irwrite;
    logic        r_mem_rd;
    logic [31:0] r_mem_addr;
    logic        r_pend_vld;
    logic [31:0] r_pend_pc;
    logic [31:0] w_redir_tgt;

    // Low address bits are forced to zero: fetches are word aligned.
    assign w_redir_tgt = redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_inst     <= 32'h0;
            r_irwrite  <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_pend_vld <= 1'b0;
            r_pend_pc  <= 32'h0;
`ifdef IFETCH_TIMEOUT_EN
            r_cnt      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (redirect)
                        r_pc <= w_redir_tgt;
                    if (fetch_req) begin
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= redirect ? w_redir_tgt : r_pc;
                        r_state    <= S_WAIT;
`ifdef IFETCH_TIMEOUT_EN
                        r_cnt      <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        r_pend_vld <= 1'b1;
                        r_pend_pc  <= w_redir_tgt;
                    end
                    if (mem_ready) begin
                        r_inst    <= mem_rdata;
                        r_mem_rd  <= 1'b0;
                        r_irwrite <= 1'b1;
                        r_state   <= S_LOAD;
                    end
`ifdef IFETCH_TIMEOUT_EN
                    else if (r_cnt == LIM) begin
                        r_mem_rd <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_LOAD: begin
                    r_irwrite  <= 1'b0;
                    r_pend_vld <= 1'b0;
                    r_state    <= S_IDLE;
                    // A same-cycle redirect beats an older pending one.
                    if (redirect)
                        r_pc <= w_redir_tgt;
                    else if (r_pend_vld)
                        r_pc <= r_pend_pc;
                    else
                        r_pc <= r_pc + 32'd4;
                end
`ifdef IFETCH_TIMEOUT_EN
                S_ERR: begin
                    r_state <= S_ERR;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign Inst     = r_inst;
    assign IRWrite  = r_irwrite;
    assign PC       = r_pc;
    assign busy     = (r_state != S_IDLE);
`ifdef IFETCH_TIMEOUT_EN
    assign fetch_err = r_err;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed testbench for ifetch_ctrl.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] Inst;
    logic        IRWrite;
    logic [31:0] PC;
    logic        busy;
    logic        fetch_err;

    int n_vec = 0;
    int n_err = 0;

    ifetch_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_req(fetch_req),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .Inst(Inst),
        .IRWrite(IRWrite),
        .PC(PC),
        .busy(busy),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b1;
        fetch_req   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_rdata   = 32'h0;
        mem_ready   = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pc", PC, 32'h0);
        chk("rst_inst", Inst, 32'h0);
        chk("rst_irw", IRWrite, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_busy", busy, 0);
        chk("rst_err", fetch_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Basic fetch, memory ready immediately
        fetch_req = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h2008_0005;
        tick();
        fetch_req = 1'b0;
        chk("f1_rd", mem_rd, 1);
        chk("f1_addr", mem_addr, 32'h0);
        chk("f1_busy", busy, 1);
        chk("f1_irw_wait", IRWrite, 0);
        tick();
        chk("f1_irw", IRWrite, 1);
        chk("f1_inst", Inst, 32'h2008_0005);
        chk("f1_rd_load", mem_rd, 0);
        mem_ready = 1'b0;
        tick();
        chk("f1_irw_off", IRWrite, 0);
        chk("f1_pc", PC, 32'h4);
        chk("f1_idle", busy, 0);
        chk("f1_inst_hold", Inst, 32'h2008_0005);

        // Delayed ready, fetch_req held high during WAIT
        fetch_req = 1'b1;
        mem_rdata = 32'hA5A5_0001;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("f2_rd", mem_rd, 1);
            chk("f2_addr", mem_addr, 32'h4);
            chk("f2_irw", IRWrite, 0);
            chk("f2_inst_hold", Inst, 32'h2008_0005);
            tick();
        end
        fetch_req = 1'b0;
        mem_ready = 1'b1;
        tick();
        chk("f2_irw_load", IRWrite, 1);
        chk("f2_inst", Inst, 32'hA5A5_0001);
        mem_ready = 1'b0;
        tick();
        chk("f2_pc", PC, 32'h8);
        chk("f2_irw_off", IRWrite, 0);
        tick();
        chk("f2_noqueue", busy, 0);
        chk("f2_noqueue_rd", mem_rd, 0);

        // Redirect during WAIT at PC=8
        fetch_req = 1'b1;
        tick();
        fetch_req   = 1'b0;
        chk("f3_addr", mem_addr, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("f3_pc_wait", PC, 32'h8);
        chk("f3_addr_stable", mem_addr, 32'h8);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ready = 1'b0;
        chk("f3_irw", IRWrite, 1);
        tick();
        chk("f3_pc", PC, 32'h40);

        // Redirect together with fetch_req in IDLE
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        fetch_req   = 1'b1;
        mem_ready   = 1'b1;
        mem_rdata   = 32'hCAFE_0001;
        tick();
        redirect  = 1'b0;
        fetch_req = 1'b0;
        chk("f4_addr", mem_addr, 32'h100);
        tick();
        chk("f4_inst", Inst, 32'hCAFE_0001);
        tick();
        chk("f4_pc", PC, 32'h104);

        // Redirect in the LOAD cycle beats PC+4
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("f5_addr", mem_addr, 32'h104);
        tick();
        chk("f5_irw", IRWrite, 1);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("f5_pc", PC, 32'h200);

        // Later pending redirect overwrites earlier one
        mem_ready = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h502;
        tick();
        redirect  = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("f6_addr", mem_addr, 32'h200);
        tick();
        chk("f6_pc", PC, 32'h500);

        // Redirect alone in IDLE, then wrap at top of memory
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        chk("f7_pc_redir", PC, 32'hFFFF_FFFC);
        chk("f7_idle", busy, 0);
        fetch_req = 1'b1;
        mem_ready = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("f7_addr", mem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        mem_ready = 1'b0;
        chk("f7_wrap", PC, 32'h0);

        // Reset in the middle of WAIT
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect  = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("f8_addr", mem_addr, 32'h80);
        #2 rst_n = 1'b0;
        #1;
        chk("f8_busy", busy, 0);
        chk("f8_rd", mem_rd, 0);
        chk("f8_pc", PC, 32'h0);
        chk("f8_addr_rst", mem_addr, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("f8_irw", IRWrite, 0);
        rst_n = 1'b1;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("f8_refetch", mem_addr, 32'h0);
        tick();
        chk("f8_inst", Inst, 32'hDEAD_BEEF);
        mem_ready = 1'b0;
        tick();
        chk("f8_pc_after", PC, 32'h4);
        chk("f8_err", fetch_err, 0);

`ifdef IFETCH_TIMEOUT_EN
        // Timeout after 16 WAIT cycles
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("to_rd", mem_rd, 1);
            chk("to_err_low", fetch_err, 0);
            tick();
        end
        chk("to_rd_last", mem_rd, 1);
        tick();
        chk("to_err", fetch_err, 1);
        chk("to_rd_off", mem_rd, 0);
        chk("to_busy", busy, 1);
        chk("to_pc", PC, 32'h4);
        chk("to_irw", IRWrite, 0);
        fetch_req = 1'b1;
        tick();
        tick();
        fetch_req = 1'b0;
        chk("to_stuck", busy, 1);
        chk("to_stuck_rd", mem_rd, 0);
        rst_n = 1'b0;
        #1;
        chk("to_clr", fetch_err, 0);
        chk("to_clr_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
